// File: rtl/mips_multicycle_ctl_pkg.sv
// Shared definitions for the multicycle MIPS controller: state encoding,
// opcode/funct constants, ALU control codes, mux-select enums and the
// per-state Moore control word.
package mips_multicycle_ctl_pkg;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_RTYPEEX = 4'd6,
      S_RTYPEWB = 4'd7,
      S_BEQEX   = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JEX     = 4'd11,
      S_HALT    = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_NOR = 6'b100111;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   typedef enum logic [1:0] {
      ALUB_REG   = 2'b00,
      ALUB_FOUR  = 2'b01,
      ALUB_SEXT  = 2'b10,
      ALUB_SHIFT = 2'b11
   } alusrcb_t;

   typedef enum logic [1:0] {
      PC_ALU    = 2'b00,
      PC_ALUOUT = 2'b01,
      PC_JUMP   = 2'b10
   } pcsrc_t;

   // Moore control word. fetch/branch/decode are qualifiers that get
   // combined with mem_ready, zero and the opcode check at the outputs.
   typedef struct packed {
      logic [3:0] alu_ctl;
      logic       alusrca;
      alusrcb_t   alusrcb;
      pcsrc_t     pcsrc;
      logic       pc_jump_wr;
      logic       fetch;
      logic       branch;
      logic       decode;
      logic       iord;
      logic       memwrite;
      logic       regwrite;
      logic       regdst;
      logic       memtoreg;
      logic       halted;
   } ctl_t;

   // Quiescent control word: no enables, selects zero, ALU set to ADD.
   function automatic ctl_t ctl_idle();
      ctl_t c;
      c.alu_ctl    = ALU_ADD;
      c.alusrca    = 1'b0;
      c.alusrcb    = ALUB_REG;
      c.pcsrc      = PC_ALU;
      c.pc_jump_wr = 1'b0;
      c.fetch      = 1'b0;
      c.branch     = 1'b0;
      c.decode     = 1'b0;
      c.iord       = 1'b0;
      c.memwrite   = 1'b0;
      c.regwrite   = 1'b0;
      c.regdst     = 1'b0;
      c.memtoreg   = 1'b0;
      c.halted     = 1'b0;
      return c;
   endfunction

   // Control word presented while sitting in state s. rtype_alu is only
   // consulted for the R-type execute state.
   function automatic ctl_t state_ctl(input state_t s, input logic [3:0] rtype_alu);
      ctl_t c;
      c = ctl_idle();
      case (s)
         S_FETCH:   begin c.alusrcb = ALUB_FOUR; c.fetch = 1'b1; end
         S_DECODE:  begin c.alusrcb = ALUB_SHIFT; c.decode = 1'b1; end
         S_MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = ALUB_SEXT; end
         S_MEMRD:   begin c.iord = 1'b1; end
         S_MEMWB:   begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
         S_MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; end
         S_RTYPEEX: begin c.alusrca = 1'b1; c.alusrcb = ALUB_REG; c.alu_ctl = rtype_alu; end
         S_RTYPEWB: begin c.regdst = 1'b1; c.regwrite = 1'b1; end
         S_BEQEX:   begin c.alusrca = 1'b1; c.alu_ctl = ALU_SUB; c.pcsrc = PC_ALUOUT; c.branch = 1'b1; end
         S_ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = ALUB_SEXT; end
         S_ADDIWB:  begin c.regwrite = 1'b1; c.regdst = 1'b0; end
         S_JEX:     begin c.pcsrc = PC_JUMP; c.pc_jump_wr = 1'b1; end
         S_HALT:    begin c.halted = 1'b1; end
         default:   begin c = ctl_idle(); end
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mips_multicycle_ctl_if.sv
// Controller <-> datapath bundle: instruction fields and status flags in,
// ALU opcode, mux selects and write enables out.
interface mips_multicycle_ctl_if;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic [3:0] alu_ctl;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic [1:0] pcsrc;
   logic       pcen;
   logic       iord;
   logic       irwrite;
   logic       memwrite;
   logic       regwrite;
   logic       regdst;
   logic       memtoreg;
   logic       illegal;
   logic       halted;

   modport master (
      input  op, funct, zero, mem_ready,
      output alu_ctl, alusrca, alusrcb, pcsrc, pcen, iord, irwrite,
             memwrite, regwrite, regdst, memtoreg, illegal, halted
   );

   modport slave (
      output op, funct, zero, mem_ready,
      input  alu_ctl, alusrca, alusrcb, pcsrc, pcen, iord, irwrite,
             memwrite, regwrite, regdst, memtoreg, illegal, halted
   );
endinterface

// File: rtl/mips_multicycle_ctl_alu_decoder.sv
// R-type funct decoder: ALU control code plus a flag saying whether the
// funct belongs to the supported subset.
module mips_alu_decoder
   import mips_multicycle_ctl_pkg::*;
(
   input  logic [5:0] funct,
   output logic [3:0] alu_ctl,
   output logic       funct_valid
);

   // Map funct onto the ALU opcode; unlisted functs fall back to ADD and are flagged invalid
   always_comb begin
      alu_ctl     = ALU_ADD;
      funct_valid = 1'b0;
      case (funct)
         FN_AND:  begin alu_ctl = ALU_AND; funct_valid = 1'b1; end
         FN_OR:   begin alu_ctl = ALU_OR;  funct_valid = 1'b1; end
         FN_ADD:  begin alu_ctl = ALU_ADD; funct_valid = 1'b1; end
         FN_SUB:  begin alu_ctl = ALU_SUB; funct_valid = 1'b1; end
         FN_SLT:  begin alu_ctl = ALU_SLT; funct_valid = 1'b1; end
         FN_NOR:  begin alu_ctl = ALU_NOR; funct_valid = 1'b1; end
         default: begin alu_ctl = ALU_ADD; funct_valid = 1'b0; end
      endcase
   end

endmodule

// File: rtl/mips_multicycle_ctl.sv
// Multicycle control FSM for the 8-bit MIPS subset. The control word for
// the next state is registered on each edge; only the mem_ready/zero
// qualified enables and the DECODE-cycle illegal flag are formed
// combinationally. While reset is high every output is forced quiescent.
module mips_multicycle_ctl
   import mips_multicycle_ctl_pkg::*;
#(
   parameter logic HALT_ON_ILLEGAL = 1'b0
)
(
   input  logic                  clk,
   input  logic                  reset,
   mips_multicycle_ctl_if.master bus
);

   state_t     state_r;
   state_t     next_s;
   ctl_t       ctl_r;
   ctl_t       ctl_s;
   logic       is_lw_r;
   logic [3:0] dec_alu_s;
   logic       dec_valid_s;
   logic       op_valid_s;

   mips_alu_decoder u_alu_decoder (
      .funct       (bus.funct),
      .alu_ctl     (dec_alu_s),
      .funct_valid (dec_valid_s)
   );

   // Opcode (and for R-type, funct) belongs to the supported subset
   always_comb begin
      op_valid_s = 1'b0;
      case (bus.op)
         OP_RTYPE:                            op_valid_s = dec_valid_s;
         OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_valid_s = 1'b1;
         default:                             op_valid_s = 1'b0;
      endcase
   end

   // Next-state selection; op/funct only matter while in DECODE
   always_comb begin
      next_s = state_r;
      case (state_r)
         S_FETCH: begin
            if (bus.mem_ready) next_s = S_DECODE;
            else               next_s = S_FETCH;
         end
         S_DECODE: begin
            if (!op_valid_s) begin
               if (HALT_ON_ILLEGAL != 1'b0) next_s = S_HALT;
               else                         next_s = S_FETCH;
            end else begin
               case (bus.op)
                  OP_RTYPE:     next_s = S_RTYPEEX;
                  OP_LW, OP_SW: next_s = S_MEMADR;
                  OP_BEQ:       next_s = S_BEQEX;
                  OP_ADDI:      next_s = S_ADDIEX;
                  OP_J:         next_s = S_JEX;
                  default:      next_s = S_FETCH;
               endcase
            end
         end
         S_MEMADR: begin
            if (is_lw_r) next_s = S_MEMRD;
            else         next_s = S_MEMWR;
         end
         S_MEMRD: begin
            if (bus.mem_ready) next_s = S_MEMWB;
            else               next_s = S_MEMRD;
         end
         S_MEMWB:   next_s = S_FETCH;
         S_MEMWR: begin
            if (bus.mem_ready) next_s = S_FETCH;
            else               next_s = S_MEMWR;
         end
         S_RTYPEEX: next_s = S_RTYPEWB;
         S_RTYPEWB: next_s = S_FETCH;
         S_BEQEX:   next_s = S_FETCH;
         S_ADDIEX:  next_s = S_ADDIWB;
         S_ADDIWB:  next_s = S_FETCH;
         S_JEX:     next_s = S_FETCH;
         S_HALT:    next_s = S_HALT;
         default:   next_s = S_FETCH;
      endcase
   end

   // State register with the control word for the state being entered; lw/sw remembered at DECODE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= S_FETCH;
         ctl_r   <= state_ctl(S_FETCH, ALU_ADD);
         is_lw_r <= 1'b0;
      end else begin
         state_r <= next_s;
         ctl_r   <= state_ctl(next_s, dec_alu_s);
         if (state_r == S_DECODE) is_lw_r <= (bus.op == OP_LW);
         else                     is_lw_r <= is_lw_r;
      end
   end

   // Hold every output quiescent while reset is asserted, independent of the clock
   always_comb begin
      if (reset) ctl_s = ctl_idle();
      else       ctl_s = ctl_r;
   end

   assign bus.alu_ctl  = ctl_s.alu_ctl;
   assign bus.alusrca  = ctl_s.alusrca;
   assign bus.alusrcb  = ctl_s.alusrcb;
   assign bus.pcsrc    = ctl_s.pcsrc;
   assign bus.pcen     = ctl_s.pc_jump_wr | (ctl_s.fetch & bus.mem_ready) | (ctl_s.branch & bus.zero);
   assign bus.irwrite  = ctl_s.fetch & bus.mem_ready;
   assign bus.iord     = ctl_s.iord;
   assign bus.memwrite = ctl_s.memwrite;
   assign bus.regwrite = ctl_s.regwrite;
   assign bus.regdst   = ctl_s.regdst;
   assign bus.memtoreg = ctl_s.memtoreg;
   assign bus.illegal  = ctl_s.decode & ~op_valid_s;
   assign bus.halted   = ctl_s.halted;

endmodule

// File: tb/tb_mips_multicycle_ctl.sv
// Scoreboard bench for mips_multicycle_ctl. Two instances run on the same
// stimulus: one resumes after an illegal instruction, one halts. Each
// instruction is expanded into its expected per-cycle control vectors from
// the instruction-level rules; the driver pushes each cycle's expectation
// as it applies inputs and a negedge monitor pops and compares.
module tb_mips_multicycle_ctl;

   typedef struct packed {
      logic [3:0] alu_ctl;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
      logic       pcen;
      logic       iord;
      logic       irwrite;
      logic       memwrite;
      logic       regwrite;
      logic       regdst;
      logic       memtoreg;
      logic       illegal;
      logic       halted;
   } vec_t;

   typedef struct {
      logic       mr;
      logic       z;
      logic [5:0] op;
      logic [5:0] funct;
      vec_t       exp;
      string      tag;
   } cyc_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   mips_multicycle_ctl_if bus0 ();
   mips_multicycle_ctl_if bus1 ();

   mips_multicycle_ctl #(.HALT_ON_ILLEGAL(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
   mips_multicycle_ctl #(.HALT_ON_ILLEGAL(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

   always #5 clk = ~clk;

   vec_t  act0, act1;
   assign act0 = {bus0.alu_ctl, bus0.alusrca, bus0.alusrcb, bus0.pcsrc, bus0.pcen, bus0.iord,
                  bus0.irwrite, bus0.memwrite, bus0.regwrite, bus0.regdst, bus0.memtoreg,
                  bus0.illegal, bus0.halted};
   assign act1 = {bus1.alu_ctl, bus1.alusrca, bus1.alusrcb, bus1.pcsrc, bus1.pcen, bus1.iord,
                  bus1.irwrite, bus1.memwrite, bus1.regwrite, bus1.regdst, bus1.memtoreg,
                  bus1.illegal, bus1.halted};

   vec_t  q0[$];
   vec_t  q1[$];
   string tq[$];
   cyc_t  prog[$];
   int    tests  = 0;
   int    fails  = 0;
   int    cyc_no = 0;
   logic  halted1 = 1'b0;

   function automatic vec_t v_base();
      vec_t v;
      v = '0;
      v.alu_ctl = 4'b0010;
      return v;
   endfunction

   function automatic vec_t v_halt();
      vec_t v;
      v = v_base();
      v.halted = 1'b1;
      return v;
   endfunction

   // ALU code for supported functs, -1 otherwise
   function automatic int ref_alu(input logic [5:0] f);
      case (f)
         6'b100100: return 0;
         6'b100101: return 1;
         6'b100000: return 2;
         6'b100010: return 6;
         6'b101010: return 7;
         6'b100111: return 12;
         default:   return -1;
      endcase
   endfunction

   task automatic add_cyc(input logic mr, input logic z, input logic [5:0] op,
                          input logic [5:0] funct, input vec_t v, input string tag);
      cyc_t c;
      c.mr = mr; c.z = z; c.op = op; c.funct = funct; c.exp = v; c.tag = tag;
      prog.push_back(c);
   endtask

   // Expand one instruction into expected cycles
   task automatic build_instr(input logic [5:0] op, input logic [5:0] funct,
                              input int fstall, input int mstall, input logic z);
      vec_t v;
      int   a;
      a = ref_alu(funct);
      v = v_base(); v.alusrcb = 2'b01;
      for (int i = 0; i < fstall; i++)
         add_cyc(1'b0, 1'($urandom), 6'($urandom), 6'($urandom), v, "fetch_wait");
      v.irwrite = 1'b1; v.pcen = 1'b1;
      add_cyc(1'b1, 1'($urandom), 6'($urandom), 6'($urandom), v, "fetch");
      v = v_base(); v.alusrcb = 2'b11;
      if (!((op == 6'b000000 && a >= 0) || op == 6'b100011 || op == 6'b101011 ||
            op == 6'b000100 || op == 6'b001000 || op == 6'b000010)) begin
         v.illegal = 1'b1;
         add_cyc(1'($urandom), 1'($urandom), op, funct, v, "decode_illegal");
         return;
      end
      add_cyc(1'($urandom), 1'($urandom), op, funct, v, "decode");
      if (op == 6'b000000) begin
         v = v_base(); v.alusrca = 1'b1; v.alusrcb = 2'b00; v.alu_ctl = 4'(a);
         add_cyc(1'($urandom), 1'($urandom), op, funct, v, "rtype_ex");
         v = v_base(); v.regdst = 1'b1; v.regwrite = 1'b1;
         add_cyc(1'($urandom), 1'($urandom), op, funct, v, "rtype_wb");
      end else if (op == 6'b100011 || op == 6'b101011) begin
         v = v_base(); v.alusrca = 1'b1; v.alusrcb = 2'b10;
         add_cyc(1'($urandom), 1'($urandom), op, funct, v, "memadr");
         v = v_base(); v.iord = 1'b1;
         if (op == 6'b101011) v.memwrite = 1'b1;
         for (int i = 0; i < mstall; i++)
            add_cyc(1'b0, 1'($urandom), op, funct, v, "mem_wait");
         add_cyc(1'b1, 1'($urandom), op, funct, v, "mem_done");
         if (op == 6'b100011) begin
            v = v_base(); v.memtoreg = 1'b1; v.regwrite = 1'b1;
            add_cyc(1'($urandom), 1'($urandom), op, funct, v, "memwb");
         end
      end else if (op == 6'b000100) begin
         v = v_base(); v.alusrca = 1'b1; v.alu_ctl = 4'b0110; v.pcsrc = 2'b01; v.pcen = z;
         add_cyc(1'($urandom), z, op, funct, v, "beq_ex");
      end else if (op == 6'b001000) begin
         v = v_base(); v.alusrca = 1'b1; v.alusrcb = 2'b10;
         add_cyc(1'($urandom), 1'($urandom), op, funct, v, "addi_ex");
         v = v_base(); v.regwrite = 1'b1;
         add_cyc(1'($urandom), 1'($urandom), op, funct, v, "addi_wb");
      end else begin
         v = v_base(); v.pcsrc = 2'b10; v.pcen = 1'b1;
         add_cyc(1'($urandom), 1'($urandom), op, funct, v, "j_ex");
      end
   endtask

   task automatic drive_inputs(input logic mr, input logic z, input logic [5:0] op, input logic [5:0] funct);
      bus0.mem_ready = mr; bus0.zero = z; bus0.op = op; bus0.funct = funct;
      bus1.mem_ready = mr; bus1.zero = z; bus1.op = op; bus1.funct = funct;
   endtask

   task automatic reset_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         reset = 1'b1;
         drive_inputs(1'($urandom), 1'($urandom), 6'($urandom), 6'($urandom));
         q0.push_back(v_base()); q1.push_back(v_base()); tq.push_back("reset");
         halted1 = 1'b0;
      end
   endtask

   // Play the built program; optionally cut it at cycle reset_at with a reset
   task automatic play(input int reset_at, input int rst_len);
      cyc_t c;
      for (int i = 0; i < prog.size(); i++) begin
         if (i == reset_at) break;
         c = prog[i];
         @(posedge clk); #1;
         reset = 1'b0;
         drive_inputs(c.mr, c.z, c.op, c.funct);
         q0.push_back(c.exp);
         q1.push_back(halted1 ? v_halt() : c.exp);
         tq.push_back(c.tag);
         if (!halted1 && c.exp.illegal) halted1 = 1'b1;
      end
      prog.delete();
      if (reset_at >= 0) reset_cycles(rst_len);
   endtask

   // Scoreboard monitor: compare both instances against the oldest expectation
   always @(negedge clk) begin
      vec_t  e0, e1;
      string t;
      cyc_no++;
      if (q0.size() > 0) begin
         e0 = q0.pop_front(); e1 = q1.pop_front(); t = tq.pop_front();
         tests++;
         if (act0 !== e0) begin
            fails++;
            $display("FAIL %s dut0 cycle %0d: got %b required %b", t, cyc_no, act0, e0);
         end
         tests++;
         if (act1 !== e1) begin
            fails++;
            $display("FAIL %s dut1 cycle %0d: got %b required %b", t, cyc_no, act1, e1);
         end
      end
   end

   logic [5:0] fn_tab [0:5];

   initial begin
      logic [5:0] op, fn;
      int         k, rs;
      fn_tab[0] = 6'b100100; fn_tab[1] = 6'b100101; fn_tab[2] = 6'b100000;
      fn_tab[3] = 6'b100010; fn_tab[4] = 6'b101010; fn_tab[5] = 6'b100111;
      drive_inputs(1'b0, 1'b0, 6'd0, 6'd0);
      reset_cycles(2);

      build_instr(6'b000000, 6'b100000, 0, 0, 1'b0); play(-1, 0);
      build_instr(6'b000100, 6'b000000, 0, 0, 1'b1); play(-1, 0);
      build_instr(6'b000100, 6'b000000, 0, 0, 1'b0); play(-1, 0);
      build_instr(6'b100011, 6'b000000, 1, 2, 1'b0); play(-1, 0);
      build_instr(6'b101011, 6'b000000, 0, 1, 1'b0); play(-1, 0);
      build_instr(6'b001000, 6'b000000, 0, 0, 1'b0); play(-1, 0);
      build_instr(6'b000010, 6'b000000, 0, 0, 1'b0); play(-1, 0);
      build_instr(6'b111111, 6'b000000, 0, 0, 1'b0); play(-1, 0);
      build_instr(6'b000000, 6'b100010, 0, 0, 1'b0); play(-1, 0);
      reset_cycles(1);
      for (int i = 0; i < 6; i++) begin
         build_instr(6'b000000, fn_tab[i], 0, 0, 1'b0); play(-1, 0);
      end
      build_instr(6'b000000, 6'b000000, 0, 0, 1'b0); play(-1, 0);
      build_instr(6'b001000, 6'b000000, 0, 0, 1'b0); play(-1, 0);
      reset_cycles(2);
      // sw cut by reset in its second MEMWR cycle, then a clean fetch
      build_instr(6'b101011, 6'b000000, 0, 3, 1'b0); play(4, 2);
      build_instr(6'b000000, 6'b100101, 0, 0, 1'b0); play(-1, 0);

      for (int n = 0; n < 300; n++) begin
         k = $urandom_range(0, 9);
         fn = fn_tab[$urandom_range(0, 5)];
         case (k)
            0, 1:    op = 6'b000000;
            2:       op = 6'b100011;
            3:       op = 6'b101011;
            4:       op = 6'b000100;
            5:       op = 6'b001000;
            6:       op = 6'b000010;
            7:       begin op = 6'b000000; fn = 6'($urandom); end
            default: op = 6'($urandom);
         endcase
         build_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom));
         if ($urandom_range(0, 19) == 0) rs = $urandom_range(0, prog.size() - 1);
         else                            rs = -1;
         play(rs, $urandom_range(1, 2));
         if (n % 25 == 24) reset_cycles(1);
      end

      @(negedge clk); #1;
      tests++;
      if (q0.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d pending expectations required 0", q0.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
